// File: rtl/clint.sv
// Core-local interruptor: 64-bit mtime/mtimecmp timer plus msip, on a simple req/ack bus.
// Define CLINT_PRESCALER_EN to add a programmable tick prescaler at offset 0x14.
module clint #(
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int          PRESCALE_W     = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ack,
    output logic        o_timer_interrupt,
    output logic        o_software_interrupt
);

    localparam logic [2:0] A_MSIP   = 3'd0;
    localparam logic [2:0] A_CMP_LO = 3'd1;
    localparam logic [2:0] A_CMP_HI = 3'd2;
    localparam logic [2:0] A_TIM_LO = 3'd3;
    localparam logic [2:0] A_TIM_HI = 3'd4;
    localparam logic [2:0] A_PRESC  = 3'd5;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic [31:0] r_rdata;
    logic        r_ack;
    logic        r_tip;

    logic        w_wr;
    logic [2:0]  w_sel;
    logic        w_tick;
    logic [31:0] w_presc_rd;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_wr     = i_req & i_we;
    assign w_sel    = i_addr[4:2];
    assign w_unused = ^i_addr[1:0];

`ifdef CLINT_PRESCALER_EN
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic                  w_presc_wr;

    assign w_presc_wr = w_wr && (w_sel == A_PRESC);
    assign w_tick     = (r_pcnt == r_prescale);
    assign w_presc_rd = 32'(r_prescale);

    // A prescale write restarts the tick phase from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prescale <= '0;
            r_pcnt     <= '0;
        end else if (w_presc_wr) begin
            r_prescale <= i_wdata[PRESCALE_W-1:0];
            r_pcnt     <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PRESCALE_W'(1);
        end
    end
`else
    localparam int unused_prescale_w = PRESCALE_W;

    assign w_tick     = 1'b1;
    assign w_presc_rd = '0;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            A_MSIP:   w_rdata = {31'd0, r_msip};
            A_CMP_LO: w_rdata = r_mtimecmp[31:0];
            A_CMP_HI: w_rdata = r_mtimecmp[63:32];
            A_TIM_LO: w_rdata = r_mtime[31:0];
            A_TIM_HI: w_rdata = r_mtime[63:32];
            A_PRESC:  w_rdata = w_presc_rd;
            default:  w_rdata = '0;
        endcase
    end

    // A half-write wins over the tick: that half loads, nothing increments.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mtime <= '0;
        end else if (w_wr && (w_sel == A_TIM_LO)) begin
            r_mtime[31:0] <= i_wdata;
        end else if (w_wr && (w_sel == A_TIM_HI)) begin
            r_mtime[63:32] <= i_wdata;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mtimecmp <= MTIMECMP_RESET;
            r_msip     <= 1'b0;
        end else if (w_wr) begin
            case (w_sel)
                A_MSIP:   r_msip             <= i_wdata[0];
                A_CMP_LO: r_mtimecmp[31:0]   <= i_wdata;
                A_CMP_HI: r_mtimecmp[63:32]  <= i_wdata;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_tip   <= 1'b0;
        end else begin
            r_ack <= i_req;
            r_tip <= (r_mtime >= r_mtimecmp);
            if (i_req) begin
                r_rdata <= i_we ? 32'd0 : w_rdata;
            end
        end
    end

    assign o_rdata              = r_rdata;
    assign o_ack                = r_ack;
    assign o_timer_interrupt    = r_tip;
    assign o_software_interrupt = r_msip;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: directed scenarios plus random bus traffic against a
// cycle-level reference model of the timer, compare and msip registers.
module tb_clint;

    localparam int PW = 16;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [4:0]  i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [31:0] o_rdata;
    logic        o_ack;
    logic        o_timer_interrupt;
    logic        o_software_interrupt;

    clint #(
        .MTIMECMP_RESET(64'hFFFF_FFFF_FFFF_FFFF),
        .PRESCALE_W    (PW)
    ) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_req               (i_req),
        .i_we                (i_we),
        .i_addr              (i_addr),
        .i_wdata             (i_wdata),
        .o_rdata             (o_rdata),
        .o_ack               (o_ack),
        .o_timer_interrupt   (o_timer_interrupt),
        .o_software_interrupt(o_software_interrupt)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0]   m_time;
    logic [63:0]   m_cmp;
    bit            m_msip;
    logic [PW-1:0] m_presc;
    int            m_since;
    logic [31:0]   m_rdata;
    bit            m_ack;
    bit            m_tip;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_time  = 64'd0;
        m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip  = 1'b0;
        m_presc = '0;
        m_since = 0;
        m_rdata = 32'd0;
        m_ack   = 1'b0;
        m_tip   = 1'b0;
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        case (a[4:2])
            3'd0: return {31'd0, m_msip};
            3'd1: return m_cmp[31:0];
            3'd2: return m_cmp[63:32];
            3'd3: return m_time[31:0];
            3'd4: return m_time[63:32];
`ifdef CLINT_PRESCALER_EN
            3'd5: return 32'(m_presc);
`endif
            default: return 32'd0;
        endcase
    endfunction

    // One clock of architectural behaviour, evaluated from pre-edge state.
    task automatic step(input bit req, input bit we, input logic [4:0] a, input logic [31:0] d);
        bit          tick;
        logic [63:0] nt;
`ifdef CLINT_PRESCALER_EN
        tick = (m_since == int'(m_presc));
`else
        tick = 1'b1;
`endif
        if (req) m_rdata = we ? 32'd0 : mread(a);
        m_ack   = req;
        m_tip   = (m_time >= m_cmp);
        nt      = tick ? m_time + 64'd1 : m_time;
        m_since = tick ? 0 : m_since + 1;
        if (req && we) begin
            case (a[4:2])
                3'd0: m_msip = d[0];
                3'd1: m_cmp[31:0] = d;
                3'd2: m_cmp[63:32] = d;
                3'd3: nt = {m_time[63:32], d};
                3'd4: nt = {d, m_time[31:0]};
`ifdef CLINT_PRESCALER_EN
                3'd5: begin
                    m_presc = d[PW-1:0];
                    m_since = 0;
                end
`endif
                default: ;
            endcase
        end
        m_time = nt;
    endtask

    task automatic cyc(input bit req, input bit we, input logic [4:0] a, input logic [31:0] d);
        i_req   = req;
        i_we    = we;
        i_addr  = a;
        i_wdata = d;
        @(posedge i_clk);
        step(req, we, a, d);
        #1;
        chk("ack", 64'(o_ack), 64'(m_ack));
        chk("rdata", 64'(o_rdata), 64'(m_rdata));
        chk("tip", 64'(o_timer_interrupt), 64'(m_tip));
        chk("sip", 64'(o_software_interrupt), 64'(m_msip));
        i_req = 1'b0;
        i_we  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [4:0] a);
        cyc(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        bit done;
        bit rq;
        bit we;
        logic [4:0]  a;
        logic [31:0] d;

        // Reset state, with a real falling edge on i_rst_n.
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_ack", 64'(o_ack), 64'd0);
        chk("rst_rdata", 64'(o_rdata), 64'd0);
        chk("rst_tip", 64'(o_timer_interrupt), 64'd0);
        chk("rst_sip", 64'(o_software_interrupt), 64'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();

        rd(5'h04);
        chk("cmp_lo_rst", 64'(o_rdata), 64'hFFFF_FFFF);
        rd(5'h08);
        chk("cmp_hi_rst", 64'(o_rdata), 64'hFFFF_FFFF);
        chk("tip_rst", 64'(o_timer_interrupt), 64'd0);

        wr(5'h00, 32'd1);
        chk("sip_set", 64'(o_software_interrupt), 64'd1);
        wr(5'h00, 32'd0);
        chk("sip_clr", 64'(o_software_interrupt), 64'd0);
        wr(5'h00, 32'hFFFF_FFFF);
        rd(5'h00);
        chk("msip_rd", 64'(o_rdata), 64'd1);
        chk("wr_rdata0", 64'(m_rdata), 64'd1);

        wr(5'h0C, 32'hFFFF_FFFE);
        wr(5'h10, 32'd0);
        idle(2);
        rd(5'h0C);
        chk("carry_lo", 64'(o_rdata), 64'd0);
        rd(5'h10);
        chk("carry_hi", 64'(o_rdata), 64'd1);

        wr(5'h10, 32'd0);
        wr(5'h0C, 32'd0);
        wr(5'h04, 32'd20);
        wr(5'h08, 32'd0);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            idle(1);
            if (m_time == 64'd20) chk("tip_at20", 64'(o_timer_interrupt), 64'd0);
            if (m_time == 64'd21) begin
                chk("tip_at21", 64'(o_timer_interrupt), 64'd1);
                done = 1'b1;
            end
        end
        if (!done) chk("tip_timeout", 64'd0, 64'd1);
        wr(5'h04, 32'hFFFF_FFFF);
        chk("tip_hold", 64'(o_timer_interrupt), 64'd1);
        wr(5'h08, 32'hFFFF_FFFF);
        chk("tip_fall", 64'(o_timer_interrupt), 64'd0);

        wr(5'h0C, 32'd5);
        rd(5'h0C);
        chk("wr_beats_tick", 64'(o_rdata), 64'd5);

`ifdef CLINT_PRESCALER_EN
        wr(5'h14, 32'd3);
        wr(5'h10, 32'd0);
        wr(5'h0C, 32'd0);
        idle(40);
        rd(5'h0C);
        chk("presc_10", 64'(o_rdata), 64'd10);
        rd(5'h14);
        chk("presc_rd", 64'(o_rdata), 64'd3);
        wr(5'h14, 32'd0);
`else
        wr(5'h14, 32'd3);
        rd(5'h14);
        chk("presc_rd0", 64'(o_rdata), 64'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            rq = ($urandom_range(0, 3) != 0);
            we = 1'($urandom_range(0, 1));
            a  = 5'($urandom);
            d  = $urandom;
            if (we && a[4:2] == 3'd5) d = $urandom_range(0, 3);
            if (we && a[4:2] == 3'd4 && $urandom_range(0, 1) == 1) d = $urandom_range(0, 1);
            cyc(rq, we, a, d);
        end

        // Reset landing mid-access must swallow that access.
        @(negedge i_clk);
        i_req  = 1'b1;
        i_we   = 1'b0;
        i_addr = 5'h04;
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 64'(o_ack), 64'd0);
        @(posedge i_clk);
        #1;
        chk("mid_rst_ack2", 64'(o_ack), 64'd0);
        i_req = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        idle(1);
        chk("no_late_ack", 64'(o_ack), 64'd0);
        rd(5'h0C);
        chk("first_tick", 64'(o_rdata), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter MTIMECMP_RESET, default 64'hFFFF_FFFF_FFFF_FFFF, which is the reset value of mtimecmp.
REQ-002 SHALL have parameter PRESCALE_W, default 16, which is the prescaler register width (used only with CLINT_PRESCALER_EN).
REQ-003 SHALL have i_clk, input, 1 bit: the clock.
REQ-004 SHALL have i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have i_req, input, 1 bit: bus access request.
REQ-006 SHALL have i_we, input, 1 bit: write when 1, read when 0.
REQ-007 SHALL have i_addr, input, 5 bits: byte offset, word-aligned; i_addr[1:0] ignored.
REQ-008 SHALL have i_wdata, input, 32 bits: write data.
REQ-009 SHALL have o_rdata, output, 32 bits: registered read data.
REQ-010 SHALL have o_ack, output, 1 bit: access completion pulse.
REQ-011 SHALL have o_timer_interrupt, output, 1 bit: timer interrupt request to the CSR unit.
REQ-012 SHALL have o_software_interrupt, output, 1 bit: software interrupt request to the CSR unit.

Function
REQ-013 SHALL decode the register map as follows:
- 0x00 msip (bit0 only; other bits read 0)
- 0x04 mtimecmp[31:0]
- 0x08 mtimecmp[63:32]
- 0x0C mtime[31:0]
- 0x10 mtime[63:32]
- 0x14 prescale
- all other offsets: read 0, writes ignored.
REQ-014 SHALL assert o_ack for exactly one cycle, on the edge following each cycle in which i_req=1; back-to-back requests SHALL produce o_ack on consecutive cycles.
REQ-015 SHALL load o_rdata on the same edge that asserts o_ack; for reads it SHALL hold the addressed register value as sampled in the request cycle, and for writes it SHALL be 0.
REQ-016 SHALL take write effect on the edge ending the request cycle; a read in the following cycle SHALL return the new value.
REQ-017 SHALL keep mtime as a 64-bit unsigned counter that increments by 1 on every tick, with carry from the low half into the high half in the same cycle.
REQ-018 SHALL wrap mtime from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-019 SHALL, when a bus write to either mtime half coincides with a tick, load the written half with i_wdata, apply no increment that cycle, and leave the other half unchanged.
REQ-020 SHALL register o_timer_interrupt as (mtime >= mtimecmp), a 64-bit unsigned comparison of the current register values, so it is valid one cycle after the condition.
REQ-021 SHALL deassert o_timer_interrupt on the edge after a mtimecmp write makes the comparison false; the level is held until then, with no latching.
REQ-022 SHALL drive o_software_interrupt directly from msip bit0 (a register output, with no extra delay).
REQ-023 SHALL accept a request regardless of o_ack state; there is no backpressure and no error response.

Reset
REQ-024 SHALL, on i_rst_n low, immediately and asynchronously set:
- mtime = 0
- mtimecmp = MTIMECMP_RESET
- msip = 0
- prescale = 0
- prescale counter = 0
- o_rdata = 0
- o_ack = 0
- o_timer_interrupt = 0
REQ-025 SHALL drop any in-flight access when reset asserts mid-access; no o_ack is issued for it after reset release.
REQ-026 SHALL count the first tick on the first rising edge after i_rst_n deasserts.

Configuration
REQ-027 SHALL, when macro CLINT_PRESCALER_EN is defined:
- make prescale a PRESCALE_W-bit read/write register at 0x14
- generate a tick when the prescale counter equals prescale; the counter then clears, otherwise it increments
- with prescale=0, tick every cycle.
REQ-028 SHALL, when CLINT_PRESCALER_EN is undefined:
- tick every cycle
- make 0x14 read 0 and ignore writes to it
- include no prescaler logic.
REQ-029 SHALL clear the prescale counter on any write to prescale.

Verification
REQ-030 SHALL cover reset release followed by a read of 0x04 and 0x08: each returns 32'hFFFF_FFFF, and o_timer_interrupt stays 0.
REQ-031 SHALL cover writing mtime lo=32'hFFFF_FFFE and hi=0, then idling for 2 cycles: a read returns lo=0 and hi=1, confirming the carry.
REQ-032 SHALL cover writing mtimecmp hi=0, lo=20 and mtime=0: o_timer_interrupt rises exactly one cycle after mtime reaches 20, and falls the cycle after mtimecmp lo is then written to 32'hFFFF_FFFF with hi=32'hFFFF_FFFF.
REQ-033 SHALL cover writing msip=1 then msip=0: o_software_interrupt goes 1 then 0, each on the edge ending its write cycle; a read of 0x00 with wdata=32'hFFFF_FFFF written returns 1.
REQ-034 SHALL cover a write to mtime lo=5 in a tick cycle: the next read returns 5, not 6.
REQ-035 SHALL cover, with CLINT_PRESCALER_EN defined, prescale=3: mtime advances by 1 every 4 cycles (10 after 40 cycles); without the macro, 0x14 reads 0.
